// File: rtl/ecc_pkg.sv
// Shared ECC definitions: widths, status encodings and the group-parity code
// used by both the write path (generation) and the read path (checking).
package ecc_pkg;

  localparam int ECC_DATA_W = 64;
  localparam int ECC_W      = 8;
  localparam int GROUP_W    = 7;
  localparam int NUM_GROUPS = 7;

  typedef enum logic [1:0] {
    ST_CLEAN  = 2'b00,  // syndrome zero
    ST_CHK    = 2'b01,  // single stored check bit flipped, data good
    ST_DATA   = 2'b10,  // single data group in error
    ST_UNCORR = 2'b11   // pattern that cannot be attributed
  } ecc_status_e;

  // Group parity over 7-bit slices plus overall parity of the whole word.
  // Bits 49..63 belong to no group; they are seen only by the overall bit.
  function automatic logic [ECC_W-1:0] ecc_calc(input logic [ECC_DATA_W-1:0] data);
    logic [ECC_W-1:0] e;
    e = '0;
    for (int g = 0; g < NUM_GROUPS; g++)
      e[g] = ^data[g*GROUP_W +: GROUP_W];
    e[ECC_W-1] = ^data;
    return e;
  endfunction

endpackage

// File: rtl/ecc_checker_if.sv
// Read-word stream into the checker and classified-word stream out of it.
interface ecc_checker_if
  import ecc_pkg::*;
#(
  parameter int ADDR_W = 28
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [ECC_DATA_W-1:0] in_data;
  logic [ECC_W-1:0]      in_ecc;
  logic [ADDR_W-1:0]     in_addr;

  logic                  out_valid;
  logic                  out_ready;
  logic [ECC_DATA_W-1:0] out_data;
  logic [ADDR_W-1:0]     out_addr;
  logic [1:0]            out_status;
  logic [2:0]            out_group;

  // Upstream/downstream side (PHY return + host port).
  modport master (
    output in_valid, in_data, in_ecc, in_addr, out_ready,
    input  in_ready, out_valid, out_data, out_addr, out_status, out_group
  );

  // Checker side.
  modport slave (
    input  in_valid, in_data, in_ecc, in_addr, out_ready,
    output in_ready, out_valid, out_data, out_addr, out_status, out_group
  );

endinterface

// File: rtl/ecc_generator.sv
// Combinational check-byte generator; thin wrapper over the shared code
// so read and write paths cannot drift apart.
module ecc_generator
  import ecc_pkg::*;
(
  input  logic [ECC_DATA_W-1:0] data,
  output logic [ECC_W-1:0]      ecc
);

  assign ecc = ecc_calc(data);

endmodule

// File: rtl/ecc_syndrome_classify.sv
// Maps an 8-bit syndrome to a status class and, for data errors, the group.
module ecc_syndrome_classify
  import ecc_pkg::*;
(
  input  logic [ECC_W-1:0] syndrome,
  output ecc_status_e      status,
  output logic [2:0]       group
);

  logic [2:0] ones;
  logic [2:0] idx;

  // Count flagged groups and remember which one (only meaningful if exactly one).
  always_comb begin
    ones = '0;
    idx  = '0;
    for (int g = 0; g < NUM_GROUPS; g++) begin
      if (syndrome[g]) begin
        ones = ones + 3'd1;
        idx  = 3'(g);
      end
    end
  end

  // Overall-parity bit disambiguates a check-bit flip from a data flip;
  // overall alone means a flip in the ungrouped top bits (group 7).
  always_comb begin
    status = ST_UNCORR;
    group  = '0;
    if (syndrome == '0) begin
      status = ST_CLEAN;
    end else if (ones == 3'd1) begin
      if (syndrome[ECC_W-1]) begin
        status = ST_DATA;
        group  = idx;
      end else begin
        status = ST_CHK;
      end
    end else if (ones == 3'd0) begin
      status = ST_DATA;
      group  = 3'd7;
    end
  end

endmodule

// File: rtl/ecc_checker.sv
// Read-path ECC checker: 2-stage valid/ready pipeline that recomputes the
// group-parity code, classifies the syndrome, passes data through untouched
// and keeps saturating per-class counters with first-error capture.
module ecc_checker
  import ecc_pkg::*;
#(
  parameter int ADDR_W = 28,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  ecc_checker_if.slave      bus,
  input  logic              clr_stats,
  output logic [CNT_W-1:0]  cnt_ce,
  output logic [CNT_W-1:0]  cnt_de,
  output logic [CNT_W-1:0]  cnt_ue,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic [ECC_W-1:0]  err_syndrome
);

  logic                  s1_valid, s2_valid;
  logic                  s1_ready, s2_ready;
  logic                  in_fire, s2_load;
  logic [ECC_DATA_W-1:0] s1_data, s2_data;
  logic [ECC_W-1:0]      s1_ecc;
  logic [ADDR_W-1:0]     s1_addr, s2_addr;
  ecc_status_e           s2_status, cls_status;
  logic [2:0]            s2_group, cls_group;
  logic [ECC_W-1:0]      recalc, syndrome;

  // A stage can take a new word if it is empty or its word leaves this cycle.
  assign s2_ready = ~s2_valid | bus.out_ready;
  assign s1_ready = ~s1_valid | s2_ready;
  assign in_fire  = bus.in_valid & s1_ready;
  assign s2_load  = s1_valid & s2_ready;

  ecc_generator u_gen (
    .data (s1_data),
    .ecc  (recalc)
  );

  assign syndrome = recalc ^ s1_ecc;

  ecc_syndrome_classify u_cls (
    .syndrome (syndrome),
    .status   (cls_status),
    .group    (cls_group)
  );

  // Stage 1: capture the raw word from the PHY side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_ecc   <= '0;
      s1_addr  <= '0;
    end else begin
      if (s1_ready) s1_valid <= bus.in_valid;
      if (in_fire) begin
        s1_data <= bus.in_data;
        s1_ecc  <= bus.in_ecc;
        s1_addr <= bus.in_addr;
      end
    end
  end

  // Stage 2: classified word; holds unchanged while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_addr   <= '0;
      s2_status <= ST_CLEAN;
      s2_group  <= '0;
    end else begin
      if (s2_ready) s2_valid <= s1_valid;
      if (s2_load) begin
        s2_data   <= s1_data;
        s2_addr   <= s1_addr;
        s2_status <= cls_status;
        s2_group  <= cls_group;
      end
    end
  end

  // Per-class saturating counters; a word counts once as it enters stage 2.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_ce <= '0;
      cnt_de <= '0;
      cnt_ue <= '0;
    end else if (clr_stats) begin
      cnt_ce <= '0;
      cnt_de <= '0;
      cnt_ue <= '0;
    end else if (s2_load) begin
      case (cls_status)
        ST_CHK:    if (cnt_ce != '1) cnt_ce <= cnt_ce + 1'b1;
        ST_DATA:   if (cnt_de != '1) cnt_de <= cnt_de + 1'b1;
        ST_UNCORR: if (cnt_ue != '1) cnt_ue <= cnt_ue + 1'b1;
        default:   ;
      endcase
    end
  end

  // First non-clean word since the last clear is latched; later ones ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid    <= 1'b0;
      err_addr     <= '0;
      err_syndrome <= '0;
    end else if (clr_stats) begin
      err_valid    <= 1'b0;
      err_addr     <= '0;
      err_syndrome <= '0;
    end else if (s2_load && cls_status != ST_CLEAN && !err_valid) begin
      err_valid    <= 1'b1;
      err_addr     <= s1_addr;
      err_syndrome <= syndrome;
    end
  end

  assign bus.in_ready   = s1_ready;
  assign bus.out_valid  = s2_valid;
  assign bus.out_data   = s2_data;
  assign bus.out_addr   = s2_addr;
  assign bus.out_status = s2_status;
  assign bus.out_group  = s2_group;

endmodule

// File: tb/tb_ecc_checker.sv
// Bench for ecc_checker: hand-derived vector table, directed corner sequences
// and a randomized stream checked against a bit-level behavioural model.
module tb_ecc_checker;

  localparam int ADDR_W  = 28;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk, rst, clr_stats;
  logic [CNT_W-1:0]  cnt_ce, cnt_de, cnt_ue;
  logic              err_valid;
  logic [ADDR_W-1:0] err_addr;
  logic [7:0]        err_syndrome;

  ecc_checker_if #(.ADDR_W(ADDR_W)) bus ();

  ecc_checker #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .clr_stats    (clr_stats),
    .cnt_ce       (cnt_ce),
    .cnt_de       (cnt_de),
    .cnt_ue       (cnt_ue),
    .err_valid    (err_valid),
    .err_addr     (err_addr),
    .err_syndrome (err_syndrome)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  e;
    logic [1:0]  st;
    logic [2:0]  grp;
    logic [7:0]  syn;
  } vec_t;

  typedef struct {
    logic [63:0]       d;
    logic [ADDR_W-1:0] a;
    logic [1:0]        st;
    logic [2:0]        grp;
  } exp_t;

  vec_t vt[12];
  exp_t sb[$];

  // model statistics
  int                m_ce, m_de, m_ue;
  bit                m_ev;
  logic [ADDR_W-1:0] m_ea;
  logic [7:0]        m_es;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Syndrome from first principles: each set data bit toggles overall parity
  // and, if it lies in bits 0..48, the parity of group bit/7.
  function automatic logic [7:0] m_syn(input logic [63:0] d, input logic [7:0] e);
    logic [7:0] s;
    s = e;
    for (int i = 0; i < 64; i++)
      if (d[i]) begin
        s[7] = ~s[7];
        if (i < 49) s[i/7] = ~s[i/7];
      end
    return s;
  endfunction

  // Returns {status, group}.
  function automatic logic [4:0] m_class(input logic [7:0] s);
    int n;
    int pos;
    n = $countones(s[6:0]);
    pos = 0;
    for (int i = 0; i < 7; i++) if (s[i]) pos = i;
    if (s == 8'h00)        return 5'b00_000;
    if (n == 1 && !s[7])   return 5'b01_000;
    if (n == 1)            return {2'b10, 3'(pos)};
    if (n == 0)            return 5'b10_111;
    return 5'b11_000;
  endfunction

  task automatic m_clear();
    m_ce = 0; m_de = 0; m_ue = 0; m_ev = 0; m_ea = '0; m_es = '0;
  endtask

  task automatic m_account(input logic [1:0] st, input logic [ADDR_W-1:0] a, input logic [7:0] s);
    case (st)
      2'b01: if (m_ce < CNT_MAX) m_ce++;
      2'b10: if (m_de < CNT_MAX) m_de++;
      2'b11: if (m_ue < CNT_MAX) m_ue++;
      default: ;
    endcase
    if (st != 2'b00 && !m_ev) begin
      m_ev = 1; m_ea = a; m_es = s;
    end
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, ".cnt_ce"}, 64'(cnt_ce), 64'(m_ce));
    chk({tag, ".cnt_de"}, 64'(cnt_de), 64'(m_de));
    chk({tag, ".cnt_ue"}, 64'(cnt_ue), 64'(m_ue));
    chk({tag, ".err"}, {err_valid, err_addr, err_syndrome}, {m_ev, m_ea, m_es});
  endtask

  task automatic do_clear();
    @(negedge clk); clr_stats = 1'b1;
    @(negedge clk); clr_stats = 1'b0;
    m_clear();
  endtask

  // One isolated word through an empty pipeline with out_ready high.
  task automatic send_one(input logic [63:0] d, input logic [7:0] e, input logic [ADDR_W-1:0] a,
                          input logic [1:0] st, input logic [2:0] grp, input logic [7:0] syn);
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = d; bus.in_ecc = e; bus.in_addr = a; bus.out_ready = 1'b1;
    #1 chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
    @(posedge clk); #1;
    chk("lat_stage1_vld", 64'(bus.out_valid), 64'd0);
    @(negedge clk); bus.in_valid = 1'b0;
    @(posedge clk); #1;
    m_account(st, a, syn);
    chk("lat_stage2_vld", 64'(bus.out_valid), 64'd1);
    chk("out_data", bus.out_data, d);
    chk("out_meta", {bus.out_addr, bus.out_status, bus.out_group}, {a, st, grp});
    chk_stats("vec");
  endtask

  task automatic gen_word(output logic [63:0] d, output logic [7:0] e, output logic [ADDR_W-1:0] a);
    int r, nf, b;
    d = {$urandom, $urandom};
    e = m_syn(d, 8'h00);
    r = $urandom_range(0, 9);
    nf = (r < 4) ? 0 : (r < 7) ? 1 : (r < 9) ? 2 : 3;
    for (int k = 0; k < nf; k++) begin
      b = $urandom_range(0, 71);
      if (b < 64) d[b] = ~d[b];
      else        e[b-64] = ~e[b-64];
    end
    a = ADDR_W'($urandom);
  endtask

  // Streams n words. rnd=1: random valid/ready. rnd=0: back-to-back input
  // with downstream stalled for 5 clocks mid-stream.
  task automatic run_stream(input int n, input bit rnd);
    int sent, got, cyc;
    bit cur_v, prev_stall;
    logic [63:0] cd, pd;
    logic [7:0]  ce;
    logic [ADDR_W-1:0] ca;
    logic [4:0]  cls;
    logic [33:0] pmeta;
    exp_t x;
    sent = 0; got = 0; cyc = 0; cur_v = 0; prev_stall = 0;
    cd = '0; ce = '0; ca = '0; pd = '0; pmeta = '0;
    while (got < n && cyc < 4000) begin
      @(negedge clk);
      if (!cur_v && sent < n && (!rnd || $urandom_range(0, 3) != 0)) begin
        gen_word(cd, ce, ca);
        cur_v = 1;
      end
      bus.in_valid = cur_v; bus.in_data = cd; bus.in_ecc = ce; bus.in_addr = ca;
      bus.out_ready = rnd ? ($urandom_range(0, 3) != 0) : !(cyc >= 3 && cyc < 8);
      #4;
      // two-entry pipeline: full only when both stages hold a word
      chk("in_ready", 64'(bus.in_ready), 64'((sent - got) < 2 || bus.out_ready));
      if (prev_stall) begin
        chk("hold_data", bus.out_data, pd);
        chk("hold_meta", {bus.out_valid, bus.out_addr, bus.out_status, bus.out_group}, {1'b1, pmeta[32:0]});
      end
      if (bus.in_valid && bus.in_ready) begin
        cls = m_class(m_syn(cd, ce));
        x.d = cd; x.a = ca; x.st = cls[4:3]; x.grp = cls[2:0];
        sb.push_back(x);
        m_account(cls[4:3], ca, m_syn(cd, ce));
        sent++;
        cur_v = 0;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 64'(bus.out_valid), 64'd0);
        end else begin
          x = sb.pop_front();
          chk("s_out_data", bus.out_data, x.d);
          chk("s_out_meta", {bus.out_addr, bus.out_status, bus.out_group}, {x.a, x.st, x.grp});
        end
        got++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      pd = bus.out_data;
      pmeta = {1'b0, bus.out_addr, bus.out_status, bus.out_group};
      cyc++;
    end
    if (cyc >= 4000) chk("stream_timeout", 64'(got), 64'(n));
    @(negedge clk); bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("stream_drained", 64'(sb.size()), 64'd0);
    chk_stats("stream");
  endtask

  initial begin
    vt[0]  = '{64'h0,             8'h00, 2'b00, 3'd0, 8'h00};
    vt[1]  = '{64'h8,             8'h00, 2'b10, 3'd0, 8'h81};
    vt[2]  = '{64'h0,             8'h04, 2'b01, 3'd0, 8'h04};
    vt[3]  = '{64'h1 << 50,       8'h00, 2'b10, 3'd7, 8'h80};
    vt[4]  = '{64'h81,            8'h00, 2'b11, 3'd0, 8'h03};
    vt[5]  = '{64'h1 << 20,       8'h00, 2'b10, 3'd2, 8'h84};
    vt[6]  = '{64'h3,             8'h00, 2'b00, 3'd0, 8'h00};
    vt[7]  = '{64'h0,             8'h80, 2'b10, 3'd7, 8'h80};
    vt[8]  = '{64'h1 << 48,       8'h00, 2'b10, 3'd6, 8'hC0};
    vt[9]  = '{64'h0,             8'h03, 2'b11, 3'd0, 8'h03};
    vt[10] = '{64'h8000_0000_0000_0000, 8'h80, 2'b00, 3'd0, 8'h00};
    vt[11] = '{64'h0,             8'hFF, 2'b11, 3'd0, 8'hFF};

    rst = 1'b1; clr_stats = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_ecc = '0; bus.in_addr = '0; bus.out_ready = 1'b0;
    m_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_out_meta", {bus.out_addr, bus.out_status, bus.out_group}, 64'd0);
    chk_stats("rst");
    @(negedge clk); rst = 1'b0;
    #1 chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // vector table
    do_clear();
    for (int i = 0; i < 12; i++)
      send_one(vt[i].d, vt[i].e, ADDR_W'(28'h100 + i), vt[i].st, vt[i].grp, vt[i].syn);

    // saturation: 5 uncorrectable words on a 2-bit counter stop at 3
    do_clear();
    for (int i = 0; i < 5; i++)
      send_one(64'h81, 8'h00, ADDR_W'(28'h200 + i), 2'b11, 3'd0, 8'h03);
    chk("sat_cnt_ue", 64'(cnt_ue), 64'd3);
    chk("sat_err_addr", 64'(err_addr), 64'h200);

    // clear coinciding with an error entering stage 2: clear wins
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 64'h81; bus.in_ecc = 8'h00; bus.in_addr = 28'h300;
    @(negedge clk);
    bus.in_valid = 1'b0; clr_stats = 1'b1;
    @(posedge clk); #1;
    m_clear();
    chk("clr_coll_vld", 64'(bus.out_valid), 64'd1);
    chk("clr_coll_st", 64'(bus.out_status), 64'd3);
    chk_stats("clr_coll");
    @(negedge clk); clr_stats = 1'b0;

    // stall sequence then random stream
    do_clear();
    run_stream(8, 1'b0);
    do_clear();
    run_stream(200, 1'b1);

    // async reset mid-stream drops words in flight
    do_clear();
    @(negedge clk);
    bus.in_valid = 1'b1; bus.in_data = 64'h81; bus.in_ecc = 8'h00; bus.in_addr = 28'h400; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_data = 64'h8; bus.in_addr = 28'h401;
    @(posedge clk); #2;
    chk("pre_rst_vld", 64'(bus.out_valid), 64'd1);
    rst = 1'b1;
    #1;
    m_clear();
    chk("async_rst_vld", 64'(bus.out_valid), 64'd0);
    chk("async_rst_data", bus.out_data, 64'd0);
    chk("async_rst_meta", {bus.out_addr, bus.out_status, bus.out_group}, 64'd0);
    chk_stats("async_rst");
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("post_rst_vld", 64'(bus.out_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
